cond_unit_it: RTL and testbench

//  Parametrised condition unit for the ARM datapath. Holds the NZCV flag register,

---
 rtl/cond_unit_it_if.sv | 38 +++
 rtl/cond_unit_it.sv | 115 +++++++++++
 tb/tb_cond_unit_it.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cond_unit_it_if.sv
// Decoder-to-condition-unit bus: per-instruction control inputs and the
// gated write strobes, flags and IT status returned to the datapath.
interface cond_unit_it_if #(
    parameter int FLAG_GROUPS = 2
);
    logic                   instr_valid;
    logic [3:0]             Cond;
    logic [3:0]             ALUFlags;
    logic [FLAG_GROUPS-1:0] FlagW;
    logic                   PCS;
    logic                   RegW;
    logic                   MemW;
    logic                   NoWrite;
    logic                   it_start;
    logic [3:0]             it_firstcond;
    logic [3:0]             it_mask;
    logic                   CondEx;
    logic                   PCSrc;
    logic                   RegWrite;
    logic                   MemWrite;
    logic [3:0]             Flags;
    logic                   in_it;
    logic                   it_err;

    // Decoder side: issues instructions, observes gated strobes
    modport master (
        output instr_valid, Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
               it_start, it_firstcond, it_mask,
        input  CondEx, PCSrc, RegWrite, MemWrite, Flags, in_it, it_err
    );

    // Condition unit side
    modport slave (
        input  instr_valid, Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
               it_start, it_firstcond, it_mask,
        output CondEx, PCSrc, RegWrite, MemWrite, Flags, in_it, it_err
    );
endinterface

// File: rtl/cond_unit_it.sv
// ARM condition unit: NZCV flag register with grouped write enables,
// condition evaluation, write-strobe gating and Thumb-2 IT block sequencing.
// FLAG_GROUPS must be 2 ({N,Z} / {C,V}) or 4 (one enable per flag).
module cond_unit_it #(
    parameter int FLAG_GROUPS = 2,
    parameter int IT_EN       = 1
) (
    input  logic          clk,
    input  logic          reset,
    cond_unit_it_if.slave bus
);

    logic [3:0] flags_q, flags_d;
    logic [7:0] itstate_q, itstate_d;
    logic       it_err_q, it_err_d;

    logic       in_it;
    logic [3:0] ec;
    logic       cond_ex;
    logic       ge;
    logic       issue;
    logic [3:0] flag_we;

    assign in_it = (itstate_q != 8'h00);

    // Inside an IT block the stored condition replaces the instruction's own field
    assign ec = in_it ? itstate_q[7:4] : bus.Cond;

    // Only real, non-IT instructions may write anything
    assign issue = bus.instr_valid & ~bus.it_start;

    // Map each flag bit {N,Z,C,V} onto the enable of the group that owns it
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_flag_we
            assign flag_we[gi] = bus.FlagW[(gi * FLAG_GROUPS) / 4];
        end
    endgenerate

    // Evaluate the effective condition against the registered flags
    always_comb begin
        ge      = (flags_q[3] == flags_q[0]);
        cond_ex = 1'b0;
        case (ec)
            4'b0000: cond_ex = flags_q[2];
            4'b0001: cond_ex = ~flags_q[2];
            4'b0010: cond_ex = flags_q[1];
            4'b0011: cond_ex = ~flags_q[1];
            4'b0100: cond_ex = flags_q[3];
            4'b0101: cond_ex = ~flags_q[3];
            4'b0110: cond_ex = flags_q[0];
            4'b0111: cond_ex = ~flags_q[0];
            4'b1000: cond_ex = flags_q[1] & ~flags_q[2];
            4'b1001: cond_ex = ~(flags_q[1] & ~flags_q[2]);
            4'b1010: cond_ex = ge;
            4'b1011: cond_ex = ~ge;
            4'b1100: cond_ex = ~flags_q[2] & ge;
            4'b1101: cond_ex = ~(~flags_q[2] & ge);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    // Load the enabled flag groups from the ALU when the instruction executes
    always_comb begin
        flags_d = flags_q;
        if (issue && cond_ex) begin
            flags_d = (flags_q & ~flag_we) | (bus.ALUFlags & flag_we);
        end
    end

    // IT sequencing: load on a legal IT, advance one slot per valid instruction
    // while in a block (even an illegal nested IT), flag misuse for one cycle
    always_comb begin
        itstate_d = itstate_q;
        it_err_d  = 1'b0;
        if (bus.instr_valid && (IT_EN != 0)) begin
            if (in_it) begin
                if (itstate_q[2:0] == 3'b000) begin
                    itstate_d = 8'h00;
                end else begin
                    itstate_d = {itstate_q[7:5], itstate_q[3:0], 1'b0};
                end
                it_err_d = bus.it_start;
            end else if (bus.it_start) begin
                if (bus.it_mask != 4'b0000) begin
                    itstate_d = {bus.it_firstcond, bus.it_mask};
                end else begin
                    it_err_d = 1'b1;
                end
            end
        end
    end

    // State registers; reset clears a block in progress without waiting for clk
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q   <= 4'b0000;
            itstate_q <= 8'h00;
            it_err_q  <= 1'b0;
        end else begin
            flags_q   <= flags_d;
            itstate_q <= itstate_d;
            it_err_q  <= it_err_d;
        end
    end

    assign bus.CondEx   = cond_ex;
    assign bus.PCSrc    = bus.PCS & cond_ex & issue;
    assign bus.RegWrite = bus.RegW & ~bus.NoWrite & cond_ex & issue;
    assign bus.MemWrite = bus.MemW & cond_ex & issue;
    assign bus.Flags    = flags_q;
    assign bus.in_it    = in_it;
    assign bus.it_err   = it_err_q;

endmodule

// File: tb/tb_cond_unit_it.sv
// Bench for cond_unit_it: three instances (2 groups, 4 groups, 4 groups without
// IT) driven in lockstep and compared against a slot-list reference model.
module tb_cond_unit_it;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cond_unit_it_if #(.FLAG_GROUPS(2)) if_a ();
    cond_unit_it_if #(.FLAG_GROUPS(4)) if_b ();
    cond_unit_it_if #(.FLAG_GROUPS(4)) if_c ();

    cond_unit_it #(.FLAG_GROUPS(2), .IT_EN(1)) u_a (.clk(clk), .reset(reset), .bus(if_a));
    cond_unit_it #(.FLAG_GROUPS(4), .IT_EN(1)) u_b (.clk(clk), .reset(reset), .bus(if_b));
    cond_unit_it #(.FLAG_GROUPS(4), .IT_EN(0)) u_c (.clk(clk), .reset(reset), .bus(if_c));

    typedef struct packed {
        logic       valid;
        logic [3:0] cond;
        logic [3:0] alu;
        logic [3:0] fw4;
        logic [1:0] fw2;
        logic       pcs;
        logic       regw;
        logic       memw;
        logic       nowr;
        logic       its;
        logic [3:0] fc;
        logic [3:0] mask;
    } stim_t;

    stim_t s;
    int    n_checks;
    int    n_fail;

    // Observed outputs {CondEx,PCSrc,RegWrite,MemWrite,Flags[3:0],in_it,it_err}
    logic [9:0] obs [3];
    always_comb begin
        obs[0] = {if_a.CondEx, if_a.PCSrc, if_a.RegWrite, if_a.MemWrite, if_a.Flags, if_a.in_it, if_a.it_err};
        obs[1] = {if_b.CondEx, if_b.PCSrc, if_b.RegWrite, if_b.MemWrite, if_b.Flags, if_b.in_it, if_b.it_err};
        obs[2] = {if_c.CondEx, if_c.PCSrc, if_c.RegWrite, if_c.MemWrite, if_c.Flags, if_c.in_it, if_c.it_err};
    end

    // Reference model: flags plus the list of conditions left in the IT block
    logic [3:0] m_flags [3];
    logic [3:0] m_slots [3][4];
    int         m_cnt   [3];
    int         m_pos   [3];
    logic       m_err   [3];

    function automatic int fg_of(input int k);
        return (k == 0) ? 2 : 4;
    endfunction

    function automatic logic iten_of(input int k);
        return (k != 2);
    endfunction

    // ARM condition semantics: base test chosen by cond[3:1], cond[0] inverts
    function automatic logic holds(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v, base;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (cond[3:1])
            3'd0:    base = z;
            3'd1:    base = c;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = c & ~z;
            3'd5:    base = (n == v);
            3'd6:    base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        if (cond == 4'hF) return 1'b0;
        return cond[0] ? ~base : base;
    endfunction

    function automatic logic [9:0] expect_out(input int k);
        logic       in_it, cx, gate;
        logic [3:0] ec;
        in_it = (m_pos[k] < m_cnt[k]);
        ec    = in_it ? m_slots[k][m_pos[k]] : s.cond;
        cx    = holds(ec, m_flags[k]);
        gate  = s.valid & ~s.its;
        return {cx, s.pcs & cx & gate, s.regw & ~s.nowr & cx & gate, s.memw & cx & gate,
                m_flags[k], in_it, m_err[k]};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_flags[k] = 4'b0000;
            m_cnt[k]   = 0;
            m_pos[k]   = 0;
            m_err[k]   = 1'b0;
        end
    endtask

    task automatic model_edge(input int k);
        logic in_it, cx;
        int   tz;
        in_it    = (m_pos[k] < m_cnt[k]);
        cx       = holds(in_it ? m_slots[k][m_pos[k]] : s.cond, m_flags[k]);
        m_err[k] = 1'b0;
        if (s.valid) begin
            if (cx && !s.its) begin
                if (fg_of(k) == 4) begin
                    for (int b = 0; b < 4; b++) if (s.fw4[b]) m_flags[k][b] = s.alu[b];
                end else begin
                    if (s.fw2[1]) m_flags[k][3:2] = s.alu[3:2];
                    if (s.fw2[0]) m_flags[k][1:0] = s.alu[1:0];
                end
            end
            if (in_it) begin
                m_pos[k] = m_pos[k] + 1;
                if (s.its && iten_of(k)) m_err[k] = 1'b1;
            end else if (s.its && iten_of(k)) begin
                if (s.mask == 4'b0000) begin
                    m_err[k] = 1'b1;
                end else begin
                    tz = 0;
                    while (s.mask[tz] == 1'b0) tz++;
                    m_cnt[k]      = 4 - tz;
                    m_pos[k]      = 0;
                    m_slots[k][0] = s.fc;
                    for (int j = 1; j < 4 - tz; j++) m_slots[k][j] = {s.fc[3:1], s.mask[4-j]};
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] o, input logic [7:0] e);
        n_checks++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    task automatic check_all();
        logic [9:0] e;
        for (int k = 0; k < 3; k++) begin
            e = expect_out(k);
            chk($sformatf("u%0d.CondEx", k),   {7'd0, obs[k][9]},   {7'd0, e[9]});
            chk($sformatf("u%0d.PCSrc", k),    {7'd0, obs[k][8]},   {7'd0, e[8]});
            chk($sformatf("u%0d.RegWrite", k), {7'd0, obs[k][7]},   {7'd0, e[7]});
            chk($sformatf("u%0d.MemWrite", k), {7'd0, obs[k][6]},   {7'd0, e[6]});
            chk($sformatf("u%0d.Flags", k),    {4'd0, obs[k][5:2]}, {4'd0, e[5:2]});
            chk($sformatf("u%0d.in_it", k),    {7'd0, obs[k][1]},   {7'd0, e[1]});
            chk($sformatf("u%0d.it_err", k),   {7'd0, obs[k][0]},   {7'd0, e[0]});
        end
    endtask

    task automatic drive();
        if_a.instr_valid = s.valid; if_b.instr_valid = s.valid; if_c.instr_valid = s.valid;
        if_a.Cond = s.cond;         if_b.Cond = s.cond;         if_c.Cond = s.cond;
        if_a.ALUFlags = s.alu;      if_b.ALUFlags = s.alu;      if_c.ALUFlags = s.alu;
        if_a.FlagW = s.fw2;         if_b.FlagW = s.fw4;         if_c.FlagW = s.fw4;
        if_a.PCS = s.pcs;           if_b.PCS = s.pcs;           if_c.PCS = s.pcs;
        if_a.RegW = s.regw;         if_b.RegW = s.regw;         if_c.RegW = s.regw;
        if_a.MemW = s.memw;         if_b.MemW = s.memw;         if_c.MemW = s.memw;
        if_a.NoWrite = s.nowr;      if_b.NoWrite = s.nowr;      if_c.NoWrite = s.nowr;
        if_a.it_start = s.its;      if_b.it_start = s.its;      if_c.it_start = s.its;
        if_a.it_firstcond = s.fc;   if_b.it_firstcond = s.fc;   if_c.it_firstcond = s.fc;
        if_a.it_mask = s.mask;      if_b.it_mask = s.mask;      if_c.it_mask = s.mask;
    endtask

    // Apply inputs, let them settle, compare all instances before the edge
    task automatic pre();
        drive();
        #1;
        check_all();
        $display("t=%0t v=%b cond=%h its=%b fc=%h mask=%h | a: cx=%b rw=%b fl=%h it=%b err=%b",
                 $time, s.valid, s.cond, s.its, s.fc, s.mask,
                 if_a.CondEx, if_a.RegWrite, if_a.Flags, if_a.in_it, if_a.it_err);
    endtask

    task automatic clk_edge();
        @(posedge clk);
        for (int k = 0; k < 3; k++) model_edge(k);
        @(negedge clk);
    endtask

    task automatic step();
        pre();
        clk_edge();
    endtask

    // Asynchronous reset pulse placed mid-cycle, away from any clock edge
    task automatic pulse_reset();
        drive();
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        reset = 1'b0;
        #1;
    endtask

    task automatic set_flags(input logic [3:0] v);
        s       = '0;
        s.valid = 1'b1;
        s.cond  = 4'hE;
        s.fw2   = 2'b11;
        s.fw4   = 4'hF;
        s.alu   = v;
        step();
        s.fw2   = 2'b00;
        s.fw4   = 4'h0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        s        = '0;
        reset    = 1'b1;
        model_reset();
        drive();
        #2;
        check_all();
        chk("rst.Flags", {4'd0, if_a.Flags}, 8'h00);
        chk("rst.in_it", {7'd0, if_a.in_it}, 8'h00);
        @(negedge clk);
        reset = 1'b0;

        // CMP setting Z, then EQ/NE on the following instructions
        set_flags(4'b0100);
        s.cond = 4'b0000; pre();
        chk("t1.Flags", {4'd0, if_a.Flags}, 8'h04);
        chk("t1.EQ", {7'd0, if_a.CondEx}, 8'h01);
        clk_edge();
        s.cond = 4'b0001; pre();
        chk("t1.NE", {7'd0, if_a.CondEx}, 8'h00);
        clk_edge();

        // Signed comparisons
        set_flags(4'b1001);
        s.cond = 4'b1010; pre(); chk("t2.GE", {7'd0, if_a.CondEx}, 8'h01); clk_edge();
        s.cond = 4'b1011; pre(); chk("t2.LT", {7'd0, if_a.CondEx}, 8'h00); clk_edge();
        set_flags(4'b1000);
        s.cond = 4'b1100; pre(); chk("t2.GT", {7'd0, if_a.CondEx}, 8'h00); clk_edge();
        s.cond = 4'b1101; pre(); chk("t2.LE", {7'd0, if_a.CondEx}, 8'h01); clk_edge();

        // Grouped flag writes
        set_flags(4'b1111);
        s.fw4 = 4'b0010; s.fw2 = 2'b01; s.alu = 4'b0000; s.cond = 4'hE;
        step();
        s.fw4 = 4'h0; s.fw2 = 2'b00;
        pre();
        chk("t3.fg4", {4'd0, if_b.Flags}, 8'h0D);
        chk("t3.fg2", {4'd0, if_a.Flags}, 8'h0C);
        clk_edge();

        // ITE EQ with Z set
        set_flags(4'b0100);
        s.regw = 1'b1; s.cond = 4'hE; s.its = 1'b1; s.fc = 4'b0000; s.mask = 4'b1100;
        pre(); chk("t4.it.RW", {7'd0, if_a.RegWrite}, 8'h00); clk_edge();
        s.its = 1'b0;
        pre(); chk("t4.i1.RW", {7'd0, if_a.RegWrite}, 8'h01); chk("t4.i1.in_it", {7'd0, if_a.in_it}, 8'h01); clk_edge();
        pre(); chk("t4.i2.RW", {7'd0, if_a.RegWrite}, 8'h00); chk("t4.i2.in_it", {7'd0, if_a.in_it}, 8'h01); clk_edge();
        pre(); chk("t4.i3.RW", {7'd0, if_a.RegWrite}, 8'h01); chk("t4.i3.in_it", {7'd0, if_a.in_it}, 8'h00); clk_edge();

        // Reset in the middle of an IT block
        s.its = 1'b1; s.fc = 4'b0001; s.mask = 4'b0010;
        step();
        s.its = 1'b0;
        step();
        s.cond = 4'b0000;
        pulse_reset();
        chk("t5.in_it", {7'd0, if_a.in_it}, 8'h00);
        chk("t5.Flags", {4'd0, if_a.Flags}, 8'h00);
        pre(); chk("t5.cond", {7'd0, if_a.CondEx}, 8'h00); clk_edge();

        // Empty mask, then bubbles and a nested IT inside a block
        s.cond = 4'hE; s.its = 1'b1; s.mask = 4'b0000;
        pre(); chk("t6.RW", {7'd0, if_a.RegWrite}, 8'h00); clk_edge();
        s.its = 1'b0; s.valid = 1'b0;
        pre(); chk("t6.err", {7'd0, if_a.it_err}, 8'h01); chk("t6.in_it", {7'd0, if_a.in_it}, 8'h00); clk_edge();
        pre(); chk("t6.err_clr", {7'd0, if_a.it_err}, 8'h00); clk_edge();
        s.valid = 1'b1; s.its = 1'b1; s.fc = 4'b0000; s.mask = 4'b0001;
        step();
        s.its = 1'b0;
        step();
        s.valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pre(); chk("t6.hold", {7'd0, if_a.in_it}, 8'h01); clk_edge();
        end
        s.valid = 1'b1; s.its = 1'b1; s.mask = 4'b1000;
        step();
        s.its = 1'b0;
        pre(); chk("t6.nest.err", {7'd0, if_a.it_err}, 8'h01); chk("t6.nest.in_it", {7'd0, if_a.in_it}, 8'h01); clk_edge();
        step();
        step();

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            s.valid = ($urandom_range(7) != 0);
            s.cond  = 4'($urandom);
            s.alu   = 4'($urandom);
            s.fw4   = 4'($urandom);
            s.fw2   = 2'($urandom);
            s.pcs   = 1'($urandom);
            s.regw  = 1'($urandom);
            s.memw  = 1'($urandom);
            s.nowr  = ($urandom_range(3) == 0);
            s.its   = ($urandom_range(5) == 0);
            s.fc    = 4'($urandom);
            s.mask  = 4'($urandom);
            if ($urandom_range(79) == 0) pulse_reset();
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
